timed_event_dispatcher: RTL

- Initiator side of the timed-output path.
- Buffers 128-bit timed instructions from the AXI write path in a FIFO and runs a 64-bit timestamp counter.
- Presents each instruction to a downstream GPO core as a one-cycle counter_matched strobe plus 128-bit event word when its timestamp is reached.
- Collects the core's busy_error/overrided feedback for error accounting and optional halt.

---
 rtl/timed_event_pkg.sv | 24 ++
 rtl/timed_event_fifo.sv | 58 +++++
 rtl/timed_event_dispatcher.sv | 121 ++++++++++++
 3 files changed

// File: rtl/timed_event_pkg.sv
// timed_event_pkg: shared widths, dispatcher state encoding and field-slice
// helpers for the timed-output initiator path.
//   Event word layout: [127:64] timestamp, [63:0] payload.
package timed_event_pkg;

  localparam int unsigned TS_W      = 64;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned EVENT_W   = 128;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_HALTED
  } state_t;

  function automatic logic [TS_W-1:0] ts_of(input logic [EVENT_W-1:0] ev);
    return ev[EVENT_W-1 -: TS_W];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] payload_of(input logic [EVENT_W-1:0] ev);
    return ev[PAYLOAD_W-1:0];
  endfunction

endpackage

// File: rtl/timed_event_fifo.sv
// timed_event_fifo: synchronous FIFO with a combinational head view.
//   clk, reset (sync, active-high)
//   push/wdata : write; ignored when full
//   pop        : remove head; ignored when empty
//   head       : current head entry (valid when !empty)
//   count      : occupancy 0..DEPTH; full / empty flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module timed_event_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/timed_event_dispatcher.sv
// timed_event_dispatcher: buffers timed instructions, runs a 64-bit timestamp
// and strobes each instruction to the GPO core when its timestamp is reached.
//   CLK100MHZ, reset (sync, active-high)
//   wr_valid/wr_ready/wr_data : instruction write ([127:64] ts, [63:0] payload)
//   start/stop/clear_ts       : control pulses; ts_now current timestamp
//   counter_matched/event_data: one-cycle dispatch strobe + held event word
//   busy_error/overrided      : core feedback, counted in error_count
//   running/halted, fifo_count, late_count, error_count : status
// Optional build macro TIMED_EVENT_DISPATCHER_LATE_DISPATCH_EN: late entries
// are dispatched (and still counted) instead of silently discarded.
module timed_event_dispatcher
  import timed_event_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter bit          HALT_ON_ERROR = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [EVENT_W-1:0]     wr_data,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear_ts,
  output logic [TS_W-1:0]        ts_now,
  output logic                   counter_matched,
  output logic [EVENT_W-1:0]     event_data,
  input  logic                   busy_error,
  input  logic                   overrided,
  output logic                   running,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       late_count,
  output logic [CNT_W-1:0]       error_count
);

`ifdef TIMED_EVENT_DISPATCHER_LATE_DISPATCH_EN
  localparam bit LATE_DISPATCH = 1'b1;
`else
  localparam bit LATE_DISPATCH = 1'b0;
`endif

  state_t               state_q;
  state_t               state_d;
  logic [EVENT_W-1:0]   head;
  logic [TS_W-1:0]      head_ts;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 err;
  logic                 on_time;
  logic                 late;
  logic                 pop;
  logic                 fire;

  assign wr_ready = ~fifo_full;
  assign running  = (state_q == ST_RUNNING);
  assign halted   = (state_q == ST_HALTED);
  assign err      = busy_error | overrided;
  assign head_ts  = ts_of(head);

  timed_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk   (CLK100MHZ),
    .reset (reset),
    .push  (wr_valid),
    .wdata (wr_data),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (start && !stop) state_d = ST_RUNNING;
      ST_RUNNING: begin
        if (stop)                     state_d = ST_STOPPED;
        else if (err && HALT_ON_ERROR) state_d = ST_HALTED;
      end
      ST_HALTED:  if (stop) state_d = ST_STOPPED;
      default:    state_d = ST_STOPPED;
    endcase
  end

  // Head compare against the pre-increment timestamp; one pop per cycle.
  always_comb begin
    on_time = 1'b0;
    late    = 1'b0;
    if (running && !fifo_empty) begin
      on_time = (head_ts == ts_now);
      late    = (head_ts <  ts_now);
    end
    pop  = on_time | late;
    fire = on_time | (late & LATE_DISPATCH);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q         <= ST_STOPPED;
      ts_now          <= '0;
      counter_matched <= 1'b0;
      event_data      <= '0;
      late_count      <= '0;
      error_count     <= '0;
    end else begin
      state_q         <= state_d;
      counter_matched <= fire;
      if (fire) event_data <= head;
      if (clear_ts)     ts_now <= '0;
      else if (running) ts_now <= ts_now + TS_W'(1);
      if (late && late_count != '1)  late_count  <= late_count + CNT_W'(1);
      if (err && error_count != '1)  error_count <= error_count + CNT_W'(1);
    end
  end

endmodule
